// File: rtl/conv_window_buffer.sv
// Raster-order line buffer and KxK window generator feeding the convolution multiplier.
// Latency: 1 cycle from pixel accept to shift_out/out_en (both registered).
// Backpressure: none; every accepted pixel is absorbed and every out_en must be taken downstream.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   frame_start       : synchronous counter restart; a pixel in the same cycle is taken as (0,0)
//   pixel_valid       : pixel_in is valid this cycle
//   pixel_in          : raster-order pixel, raw bits
//   shift_out         : flattened window, element (r,c) at [(r*K+c)*BITS +: BITS],
//                       r=0 oldest row, c=0 oldest column, newest pixel in the MSBs
//   out_en            : one-cycle strobe, shift_out holds a new in-image window
//   frame_done        : one-cycle strobe after the last pixel of a frame
//   win_count         : (only with WINDOW_CNT_EN) saturating count of windows since reset/frame_start
//
// Optional build macro: WINDOW_CNT_EN adds the win_count port and its counter.

module conv_window_buffer #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      frame_start,
  input  logic                                      pixel_valid,
  input  logic [BITS-1:0]                           pixel_in,
  output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0]   shift_out,
  output logic                                      out_en,
  output logic                                      frame_done
`ifdef WINDOW_CNT_EN
  ,
  output logic [15:0]                               win_count
`endif
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef logic [BITS-1:0] pix_t;

  // Position counters of the next pixel to be accepted.
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  // Position of the pixel seen this cycle; frame_start forces it to (0,0).
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;

  // lb_q[r][x] holds the pixel at column x from row (row - (K-1-r)):
  // lb_q[K-2] is the previous row, lb_q[0] the oldest retained row.
  pix_t lb_q  [K-1][IMG_WIDTH];

  // Window registers, win_q[r][c] is element (r,c).
  pix_t win_q [K][K];

  // Column entering the right edge of the window on this accept.
  pix_t new_col [K];

  logic win_done;
  logic last_px;

  always_comb begin
    col_eff = frame_start ? '0 : col_q;
    row_eff = frame_start ? '0 : row_q;

    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = lb_q[r][col_eff];
    end
    new_col[K-1] = pixel_in;

    // Only pixels far enough right and down complete a window; this also
    // hides stale line-buffer data left over from the previous frame.
    win_done = pixel_valid
               && (row_eff >= RW'(K - 1))
               && (col_eff >= CW'(K - 1));

    last_px  = pixel_valid
               && (row_eff == RW'(IMG_HEIGHT - 1))
               && (col_eff == CW'(IMG_WIDTH - 1));
  end

  // Raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pixel_valid) begin
      if (col_eff == CW'(IMG_WIDTH - 1)) begin
        col_q <= '0;
        row_q <= (row_eff == RW'(IMG_HEIGHT - 1)) ? '0 : row_eff + RW'(1);
      end else begin
        col_q <= col_eff + CW'(1);
        row_q <= row_eff;
      end
    end else if (frame_start) begin
      col_q <= '0;
      row_q <= '0;
    end
  end

  // Line buffers: each column slot moves one row up, the newest row takes pixel_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K - 1; r++) begin
        for (int x = 0; x < IMG_WIDTH; x++) begin
          lb_q[r][x] <= '0;
        end
      end
    end else if (pixel_valid) begin
      for (int r = 0; r < K - 1; r++) begin
        lb_q[r][col_eff] <= new_col[r+1];
      end
    end
  end

  // Window: shift every row left by one column and load the new right column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (pixel_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][K-1] <= new_col[r];
      end
    end
  end

  // Strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_en     <= win_done;
      frame_done <= last_px;
    end
  end

  // The window registers are the output register; flatten them.
  always_comb begin
    shift_out = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        shift_out[(r*K+c)*BITS +: BITS] = win_q[r][c];
      end
    end
  end

`ifdef WINDOW_CNT_EN
  // frame_start wins over a coincident window so a restart always reads back 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_count <= '0;
    end else if (frame_start) begin
      win_count <= '0;
    end else if (win_done && (win_count != 16'hFFFF)) begin
      win_count <= win_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
module tb_conv_window_buffer;

  localparam int BITS = 9;
  localparam int K    = 3;
  localparam int W    = 5;
  localparam int H    = 4;
  localparam int WW   = K*K*BITS;

  logic          clk;
  logic          rst_n;
  logic          frame_start;
  logic          pixel_valid;
  logic [BITS-1:0] pixel_in;
  logic [WW-1:0] shift_out;
  logic          out_en;
  logic          frame_done;
`ifdef WINDOW_CNT_EN
  logic [15:0]   win_count;
`endif

  conv_window_buffer #(
    .BITS(BITS), .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .pixel_valid(pixel_valid),
    .pixel_in(pixel_in),
    .shift_out(shift_out),
    .out_en(out_en),
    .frame_done(frame_done)
`ifdef WINDOW_CNT_EN
    ,
    .win_count(win_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] win;
    bit            fd;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_chk  = 0;
  int n_fail = 0;

  // independent reference raster model
  logic [BITS-1:0] img [H][W];
  int m_row, m_col, m_wc;

  // monitor state
  bit            mon_en   = 1'b0;
  bit            last_acc = 1'b0;
  logic [WW-1:0] prev_so  = '0;
  int            out_cnt, fd_cnt;
  logic [WW-1:0] first_win, fd_win;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] pack9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
    int v[9];
    logic [WW-1:0] p;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    p = '0;
    for (int i = 0; i < 9; i++) p[i*BITS +: BITS] = BITS'(v[i]);
    return p;
  endfunction

  // Drive one cycle of inputs and predict what the DUT will emit for it.
  task automatic drive(input bit v, input bit fs, input int d);
    exp_t x;
    @(posedge clk);
    #1;
    pixel_valid = v;
    frame_start = fs;
    pixel_in    = BITS'(d);
    if (fs) begin
      m_row = 0;
      m_col = 0;
      m_wc  = 0;
    end
    if (v) begin
      img[m_row][m_col] = BITS'(d);
      if (m_row >= K-1 && m_col >= K-1) begin
        x.win = '0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            x.win[(r*K+c)*BITS +: BITS] = img[m_row-(K-1)+r][m_col-(K-1)+c];
        x.fd = (m_row == H-1) && (m_col == W-1);
        q.push_back(x);
        m_wc++;
      end
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
  endtask

  // One full frame of values row*W+col+1; optional stall between pixels.
  task automatic run_frame(input bit stall, input bit fs_first);
    for (int i = 0; i < W*H; i++) begin
      drive(1'b1, fs_first && (i == 0), i + 1);
`ifdef WINDOW_CNT_EN
      if (fs_first && i == 1) check_val("win_count_after_frame_start", win_count, 0);
`endif
      if (stall) drive(1'b0, 1'b0, 0);
    end
    idle(3);
  endtask

  task automatic clear_stats();
    out_cnt   = 0;
    fd_cnt    = 0;
    first_win = '0;
    fd_win    = '0;
  endtask

  task automatic check_frame(input string tag);
    check_val({tag, "_out_en_count"}, out_cnt, (H-K+1)*(W-K+1));
    check_val({tag, "_frame_done_count"}, fd_cnt, 1);
    check_val({tag, "_first_window"}, first_win, pack9(1, 2, 3, 6, 7, 8, 11, 12, 13));
    check_val({tag, "_last_window"}, fd_win, pack9(8, 9, 10, 13, 14, 15, 18, 19, 20));
    check_val({tag, "_queue_drained"}, q.size(), 0);
  endtask

  always @(posedge clk) last_acc <= pixel_valid;

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_en) begin
        out_cnt++;
        if (q.size() == 0) begin
          check_val("spurious_out_en", out_en, 0);
        end else begin
          e = q.pop_front();
          check_val("window", shift_out, e.win);
          check_val("frame_done_with_window", frame_done, e.fd);
        end
        if (out_cnt == 1) first_win = shift_out;
        if (frame_done) fd_win = shift_out;
      end else if (frame_done) begin
        check_val("frame_done_without_out_en", frame_done, 0);
      end
      if (frame_done) fd_cnt++;
      if (!last_acc) begin
        check_val("idle_out_en", out_en, 0);
        check_val("idle_hold", shift_out, prev_so);
      end
    end
    prev_so = shift_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    m_row = 0; m_col = 0; m_wc = 0;
    clear_stats();
    #1;
    check_val("reset_shift_out", shift_out, 0);
    check_val("reset_out_en", out_en, 0);
    check_val("reset_frame_done", frame_done, 0);
`ifdef WINDOW_CNT_EN
    check_val("reset_win_count", win_count, 0);
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Test 1: asynchronous reset mid-stream
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 100 + i);
    @(posedge clk);
    #2;
    pixel_valid = 1'b0;
    check_val("pre_reset_window_loaded", shift_out != '0, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_val("async_reset_shift_out", shift_out, 0);
    check_val("async_reset_out_en", out_en, 0);
    check_val("async_reset_frame_done", frame_done, 0);
`ifdef WINDOW_CNT_EN
    check_val("async_reset_win_count", win_count, 0);
`endif
    q.delete();
    m_row = 0; m_col = 0; m_wc = 0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Test 2/4: basic frame, continuous valid (first window only after 2*W+3 pixels)
    clear_stats();
    run_frame(1'b0, 1'b0);
    check_frame("basic");
`ifdef WINDOW_CNT_EN
    check_val("win_count_one_frame", win_count, 6);
`endif

    // Test 3: same frame with alternating stalls
    clear_stats();
    run_frame(1'b1, 1'b0);
    check_frame("stall");
`ifdef WINDOW_CNT_EN
    check_val("win_count_two_frames", win_count, 12);
`endif

    // Test 5: abandon frame A after 9 pixels, restart with frame_start
    clear_stats();
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 200 + i);
    run_frame(1'b0, 1'b1);
    check_frame("restart");
`ifdef WINDOW_CNT_EN
    check_val("win_count_after_restart_frame", win_count, m_wc);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
